// File: rtl/vtg_pkg.sv
// Shared types and helpers for the raster timing generator.
package vtg_pkg;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam int unsigned VGA_H_ACT = 640;
  localparam int unsigned VGA_H_FP  = 16;
  localparam int unsigned VGA_H_SP  = 96;
  localparam int unsigned VGA_H_BP  = 48;
  localparam int unsigned VGA_V_ACT = 480;
  localparam int unsigned VGA_V_FP  = 10;
  localparam int unsigned VGA_V_SP  = 2;
  localparam int unsigned VGA_V_BP  = 33;
  localparam bit          VGA_H_POL = 1'b0;
  localparam bit          VGA_V_POL = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t act;
    cnt_t fp;
    cnt_t sp;
    cnt_t bp;
    logic pol;
  } axis_cfg_t;

  typedef struct packed {
    axis_cfg_t h;
    axis_cfg_t v;
  } timing_cfg_t;

  typedef struct packed {
    cnt_t total_m1;
    cnt_t sync_start;
    cnt_t sync_end;
  } axis_lim_t;

  // Sums carry one extra bit so a full 2^CNT_W total still yields a valid total-1.
  function automatic axis_lim_t calc_lim(input axis_cfg_t c);
    logic [SUM_W-1:0] ss;
    logic [SUM_W-1:0] se;
    logic [SUM_W-1:0] tot;
    axis_lim_t        l;
    ss           = SUM_W'(c.act) + SUM_W'(c.fp);
    se           = ss + SUM_W'(c.sp);
    tot          = se + SUM_W'(c.bp);
    l.total_m1   = CNT_W'(tot - SUM_W'(1));
    l.sync_start = CNT_W'(ss);
    l.sync_end   = CNT_W'(se);
    return l;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Config and video-output bundle between the timing generator and its users.
interface video_timing_gen_if;
  import vtg_pkg::*;

  logic enable;
  cnt_t cfg_h_act;
  cnt_t cfg_h_fp;
  cnt_t cfg_h_sp;
  cnt_t cfg_h_bp;
  cnt_t cfg_v_act;
  cnt_t cfg_v_fp;
  cnt_t cfg_v_sp;
  cnt_t cfg_v_bp;
  logic cfg_h_pol;
  logic cfg_v_pol;
  logic cfg_load;
  logic cfg_pending;
  logic hsync;
  logic vsync;
  logic de;
  cnt_t pixel_x;
  cnt_t pixel_y;
  logic line_start;
  logic frame_start;
  logic hblank;
  logic vblank;

  modport master (
    output enable, cfg_h_act, cfg_h_fp, cfg_h_sp, cfg_h_bp,
           cfg_v_act, cfg_v_fp, cfg_v_sp, cfg_v_bp, cfg_h_pol, cfg_v_pol, cfg_load,
    input  cfg_pending, hsync, vsync, de, pixel_x, pixel_y,
           line_start, frame_start, hblank, vblank
  );

  modport slave (
    input  enable, cfg_h_act, cfg_h_fp, cfg_h_sp, cfg_h_bp,
           cfg_v_act, cfg_v_fp, cfg_v_sp, cfg_v_bp, cfg_h_pol, cfg_v_pol, cfg_load,
    output cfg_pending, hsync, vsync, de, pixel_x, pixel_y,
           line_start, frame_start, hblank, vblank
  );

endinterface

// File: rtl/vtg_axis.sv
// One raster axis: position counter, wrap detect and active/sync window decode.
module vtg_axis
  import vtg_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr_i,
  input  logic      adv_i,
  input  cnt_t      act_i,
  input  axis_lim_t lim_i,
  output logic      wrap_c,
  output cnt_t      cnt_o,
  output logic      in_active_c,
  output logic      in_sync_c
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  always_comb begin
    wrap_c = adv_i && (cnt_q == lim_i.total_m1);
    cnt_d  = cnt_q;
    if (clr_i || wrap_c) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_active_c = (cnt_q < act_i);
    in_sync_c   = (cnt_q >= lim_i.sync_start) && (cnt_q < lim_i.sync_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with frame-boundary config shadowing.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned RST_H_ACT = VGA_H_ACT,
  parameter int unsigned RST_H_FP  = VGA_H_FP,
  parameter int unsigned RST_H_SP  = VGA_H_SP,
  parameter int unsigned RST_H_BP  = VGA_H_BP,
  parameter int unsigned RST_V_ACT = VGA_V_ACT,
  parameter int unsigned RST_V_FP  = VGA_V_FP,
  parameter int unsigned RST_V_SP  = VGA_V_SP,
  parameter int unsigned RST_V_BP  = VGA_V_BP,
  parameter bit          RST_H_POL = VGA_H_POL,
  parameter bit          RST_V_POL = VGA_V_POL
) (
  input logic               clk,
  input logic               rst_n,
  video_timing_gen_if.slave bus
);

  localparam axis_cfg_t RST_H = '{act: CNT_W'(RST_H_ACT), fp: CNT_W'(RST_H_FP),
                                  sp: CNT_W'(RST_H_SP), bp: CNT_W'(RST_H_BP), pol: RST_H_POL};
  localparam axis_cfg_t RST_V = '{act: CNT_W'(RST_V_ACT), fp: CNT_W'(RST_V_FP),
                                  sp: CNT_W'(RST_V_SP), bp: CNT_W'(RST_V_BP), pol: RST_V_POL};
  localparam axis_lim_t RST_H_LIM = calc_lim(RST_H);
  localparam axis_lim_t RST_V_LIM = calc_lim(RST_V);

  timing_cfg_t cfg_in_c;
  logic        idle_c;
  logic        frame_end_c;
  logic        apply_c;
  timing_cfg_t src_c;

  cnt_t        h_act_q, h_act_d, v_act_q, v_act_d;
  logic        h_pol_q, h_pol_d, v_pol_q, v_pol_d;
  axis_lim_t   h_lim_q, h_lim_d, v_lim_q, v_lim_d;
  timing_cfg_t pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;

  logic h_wrap_c, v_wrap_c, h_active_c, v_active_c, h_sync_c, v_sync_c;
  cnt_t h_cnt, v_cnt;

  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d;
  cnt_t pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

  assign cfg_in_c = '{
    h: '{act: bus.cfg_h_act, fp: bus.cfg_h_fp, sp: bus.cfg_h_sp, bp: bus.cfg_h_bp, pol: bus.cfg_h_pol},
    v: '{act: bus.cfg_v_act, fp: bus.cfg_v_fp, sp: bus.cfg_v_sp, bp: bus.cfg_v_bp, pol: bus.cfg_v_pol}
  };
  assign idle_c      = ~bus.enable;
  assign frame_end_c = h_wrap_c & v_wrap_c;

  vtg_axis u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (idle_c),
    .adv_i       (bus.enable),
    .act_i       (h_act_q),
    .lim_i       (h_lim_q),
    .wrap_c      (h_wrap_c),
    .cnt_o       (h_cnt),
    .in_active_c (h_active_c),
    .in_sync_c   (h_sync_c)
  );

  vtg_axis u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (idle_c),
    .adv_i       (h_wrap_c),
    .act_i       (v_act_q),
    .lim_i       (v_lim_q),
    .wrap_c      (v_wrap_c),
    .cnt_o       (v_cnt),
    .in_active_c (v_active_c),
    .in_sync_c   (v_sync_c)
  );

  // The active set may only change while idle or on the frame_end cycle.
  always_comb begin
    apply_c    = 1'b0;
    src_c      = cfg_in_c;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (idle_c || frame_end_c) begin
      if (bus.cfg_load) begin
        apply_c    = 1'b1;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        apply_c    = 1'b1;
        src_c      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (bus.cfg_load) begin
      pend_d     = cfg_in_c;
      pend_vld_d = 1'b1;
    end

    h_act_d = h_act_q;
    h_pol_d = h_pol_q;
    h_lim_d = h_lim_q;
    v_act_d = v_act_q;
    v_pol_d = v_pol_q;
    v_lim_d = v_lim_q;
    if (apply_c) begin
      h_act_d = src_c.h.act;
      h_pol_d = src_c.h.pol;
      h_lim_d = calc_lim(src_c.h);
      v_act_d = src_c.v.act;
      v_pol_d = src_c.v.pol;
      v_lim_d = calc_lim(src_c.v);
    end
  end

  // Output decode for the current counter state; idle forces the inactive levels.
  always_comb begin
    hsync_d       = ~h_pol_q;
    vsync_d       = ~v_pol_q;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    hblank_d      = 1'b0;
    vblank_d      = 1'b0;
    pixel_x_d     = '0;
    pixel_y_d     = '0;
    if (bus.enable) begin
      hsync_d       = h_sync_c ? h_pol_q : ~h_pol_q;
      vsync_d       = v_sync_c ? v_pol_q : ~v_pol_q;
      de_d          = h_active_c & v_active_c;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      hblank_d      = ~h_active_c;
      vblank_d      = ~v_active_c;
      pixel_x_d     = h_cnt;
      pixel_y_d     = v_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_act_q       <= RST_H.act;
      h_pol_q       <= RST_H.pol;
      h_lim_q       <= RST_H_LIM;
      v_act_q       <= RST_V.act;
      v_pol_q       <= RST_V.pol;
      v_lim_q       <= RST_V_LIM;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      hsync_q       <= ~RST_H_POL;
      vsync_q       <= ~RST_V_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
    end else begin
      h_act_q       <= h_act_d;
      h_pol_q       <= h_pol_d;
      h_lim_q       <= h_lim_d;
      v_act_q       <= v_act_d;
      v_pol_q       <= v_pol_d;
      v_lim_q       <= v_lim_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
    end
  end

  assign bus.cfg_pending = pend_vld_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.hblank      = hblank_q;
  assign bus.vblank      = vblank_q;
  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against a frame-position reference model.
module tb_video_timing_gen;
  import vtg_pkg::*;

  localparam int unsigned OW = 8 + 2 * CNT_W;
  typedef logic [OW-1:0] ov_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if bus ();

  video_timing_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  timing_cfg_t def_cfg, tiny_cfg, cur_cfg;
  timing_cfg_t m_act, m_pend;
  bit          m_pvld;
  int          m_pos;

  task automatic check(input string tag, input ov_t got, input ov_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int tot(input axis_cfg_t a);
    return int'(a.act) + int'(a.fp) + int'(a.sp) + int'(a.bp);
  endfunction

  // Expected outputs for frame position pos under mode m (h = pos mod line length).
  function automatic ov_t decode(input bit en, input int pos, input timing_cfg_t m, input bit pend);
    int ht, h, v, hss, vss;
    bit hs, vs, de, ls, fs, hb, vb;
    if (!en) return {pend, ~m.h.pol, ~m.v.pol, 5'b0, {(2*CNT_W){1'b0}}};
    ht  = tot(m.h);
    h   = pos % ht;
    v   = pos / ht;
    hss = int'(m.h.act) + int'(m.h.fp);
    vss = int'(m.v.act) + int'(m.v.fp);
    hs  = (h >= hss && h < hss + int'(m.h.sp)) ? m.h.pol : ~m.h.pol;
    vs  = (v >= vss && v < vss + int'(m.v.sp)) ? m.v.pol : ~m.v.pol;
    de  = (h < int'(m.h.act)) && (v < int'(m.v.act));
    ls  = (h == 0);
    fs  = (h == 0) && (v == 0);
    hb  = (h >= int'(m.h.act));
    vb  = (v >= int'(m.v.act));
    return {pend, hs, vs, de, ls, fs, hb, vb, CNT_W'(h), CNT_W'(v)};
  endfunction

  function automatic ov_t observed();
    return {bus.cfg_pending, bus.hsync, bus.vsync, bus.de, bus.line_start, bus.frame_start,
            bus.hblank, bus.vblank, bus.pixel_x, bus.pixel_y};
  endfunction

  function automatic ov_t reset_vec();
    return {1'b0, ~VGA_H_POL, ~VGA_V_POL, 5'b0, {(2*CNT_W){1'b0}}};
  endfunction

  function automatic timing_cfg_t rnd_mode();
    timing_cfg_t c;
    c.h.act = CNT_W'($urandom_range(1, 20));
    c.h.fp  = CNT_W'($urandom_range(1, 4));
    c.h.sp  = CNT_W'($urandom_range(1, 4));
    c.h.bp  = CNT_W'($urandom_range(1, 4));
    c.h.pol = 1'($urandom_range(0, 1));
    c.v.act = CNT_W'($urandom_range(1, 8));
    c.v.fp  = CNT_W'($urandom_range(1, 3));
    c.v.sp  = CNT_W'($urandom_range(1, 3));
    c.v.bp  = CNT_W'($urandom_range(1, 3));
    c.v.pol = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic set_cfg(input timing_cfg_t c);
    cur_cfg       = c;
    bus.cfg_h_act = c.h.act;
    bus.cfg_h_fp  = c.h.fp;
    bus.cfg_h_sp  = c.h.sp;
    bus.cfg_h_bp  = c.h.bp;
    bus.cfg_h_pol = c.h.pol;
    bus.cfg_v_act = c.v.act;
    bus.cfg_v_fp  = c.v.fp;
    bus.cfg_v_sp  = c.v.sp;
    bus.cfg_v_bp  = c.v.bp;
    bus.cfg_v_pol = c.v.pol;
  endtask

  task automatic model_reset();
    m_act  = def_cfg;
    m_pend = def_cfg;
    m_pvld = 1'b0;
    m_pos  = 0;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare.
  task automatic cyc(input string tag);
    bit          en, ld, fe;
    timing_cfg_t old;
    ov_t         e;
    @(posedge clk);
    en  = bus.enable;
    ld  = bus.cfg_load;
    old = m_act;
    fe  = en && (m_pos == tot(old.h) * tot(old.v) - 1);
    if (!en || fe) begin
      if (ld) begin
        m_act  = cur_cfg;
        m_pvld = 1'b0;
      end else if (m_pvld) begin
        m_act  = m_pend;
        m_pvld = 1'b0;
      end
    end else if (ld) begin
      m_pend = cur_cfg;
      m_pvld = 1'b1;
    end
    e     = decode(en, m_pos, old, m_pvld);
    m_pos = (!en || fe) ? 0 : m_pos + 1;
    #1;
    check(tag, observed(), e);
  endtask

  task automatic load(input timing_cfg_t c, input string tag);
    set_cfg(c);
    bus.cfg_load = 1'b1;
    cyc(tag);
    bus.cfg_load = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic run_to(input int p, input string tag);
    int i;
    i = 0;
    while (m_pos != p && i < 5000) begin
      cyc(tag);
      i++;
    end
    if (m_pos != p) check({tag, "_timeout"}, OW'(m_pos), OW'(p));
  endtask

  function automatic int frame_len();
    return tot(m_act.h) * tot(m_act.v);
  endfunction

  initial begin
    int nde, nhs, first_fs, k;
    timing_cfg_t a, b;

    def_cfg  = '{h: '{act: CNT_W'(VGA_H_ACT), fp: CNT_W'(VGA_H_FP), sp: CNT_W'(VGA_H_SP),
                      bp: CNT_W'(VGA_H_BP), pol: VGA_H_POL},
                 v: '{act: CNT_W'(VGA_V_ACT), fp: CNT_W'(VGA_V_FP), sp: CNT_W'(VGA_V_SP),
                      bp: CNT_W'(VGA_V_BP), pol: VGA_V_POL}};
    tiny_cfg = '{h: '{act: CNT_W'(4), fp: CNT_W'(1), sp: CNT_W'(2), bp: CNT_W'(1), pol: 1'b1},
                 v: '{act: CNT_W'(3), fp: CNT_W'(1), sp: CNT_W'(1), bp: CNT_W'(1), pol: 1'b1}};
    bus.enable   = 1'b1;
    bus.cfg_load = 1'b0;
    set_cfg(def_cfg);
    model_reset();

    #12;
    check("reset_state", observed(), reset_vec());
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Default mode: one full line
    nde = 0;
    nhs = 0;
    for (int i = 0; i < 800; i++) begin
      cyc("vga_line");
      if (bus.de) nde++;
      if (!bus.hsync) nhs++;
    end
    check("vga_de_per_line", OW'(nde), OW'(640));
    check("vga_hsync_width", OW'(nhs), OW'(96));

    // Tiny mode written while idle, then started
    bus.enable = 1'b0;
    run(3, "idle");
    load(tiny_cfg, "idle_load");
    run(2, "idle");
    bus.enable = 1'b1;
    cyc("tiny_start");
    check("tiny_first_fs", OW'(bus.frame_start), OW'(1));
    nde      = (bus.de === 1'b1) ? 1 : 0;
    first_fs = -1;
    for (int i = 1; i <= 100; i++) begin
      cyc("tiny_run");
      if (i < 48 && bus.de) nde++;
      if (bus.frame_start && first_fs < 0) first_fs = i;
    end
    check("tiny_frame_period", OW'(first_fs), OW'(48));
    check("tiny_de_per_frame", OW'(nde), OW'(12));

    // Mid-frame load waits for the frame boundary
    a = rnd_mode();
    run_to(frame_len() / 2, "pre_mid");
    load(a, "mid_load");
    check("pending_set", OW'(bus.cfg_pending), OW'(1));
    k = 0;
    while (m_pvld && k < 5000) begin
      cyc("pend_wait");
      k++;
    end
    run(2 * frame_len(), "mode_a");

    // Load coincident with frame_end bypasses pending
    b = rnd_mode();
    run_to(frame_len() - 1, "pre_fe");
    load(b, "fe_load");
    check("fe_no_pending", OW'(bus.cfg_pending), OW'(0));
    run(2 * frame_len(), "mode_b");

    // Two loads in one frame: the later one wins
    a = rnd_mode();
    b = rnd_mode();
    run_to(1, "pre_two");
    load(a, "two_load_a");
    run(2, "two_gap");
    load(b, "two_load_b");
    run_to(0, "two_wait");
    run(2 * frame_len(), "two_after");

    // Enable dropped mid-frame, restored 10 clk later
    run_to(frame_len() / 2, "pre_drop");
    bus.enable = 1'b0;
    run(10, "dropped");
    bus.enable = 1'b1;
    cyc("resume");
    check("resume_fs", OW'(bus.frame_start), OW'(1));
    run(frame_len(), "after_resume");

    // Random loads and enable drops
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        load(rnd_mode(), "rnd_load");
      end else if ($urandom_range(0, 299) == 0) begin
        bus.enable = 1'b0;
        run($urandom_range(1, 5), "rnd_idle");
        bus.enable = 1'b1;
      end else begin
        cyc("rnd_run");
      end
    end

    // Asynchronous reset mid-frame
    run_to(frame_len() / 2, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", observed(), reset_vec());
    @(posedge clk);
    #1;
    check("reset_hold", observed(), reset_vec());
    #1 rst_n = 1'b1;
    set_cfg(def_cfg);
    model_reset();
    cyc("post_reset");
    check("post_reset_fs", OW'(bus.frame_start), OW'(1));
    run(300, "post_reset_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Runtime-programmable raster timing generator for the display pipeline. It drives the TextVRAM pixel fetch and the video output stage.
- Horizontal and vertical geometry and sync polarities come from config inputs, not fixed parameters.
- Config is double-buffered and takes effect only at a frame boundary, so mode switches are tear-free.
- All outputs are registered and mutually aligned.
- Adds line_start / frame_start strobes, blanking flags and a run/idle enable.

Parameters:
CNT_W, 12, width of counters, coordinates and config fields
RST_H_ACT, 640, reset value of active horizontal config
RST_H_FP, 16, reset h front porch
RST_H_SP, 96, reset h sync pulse
RST_H_BP, 48, reset h back porch
RST_V_ACT, 480, reset v active
RST_V_FP, 10, reset v front porch
RST_V_SP, 2, reset v sync pulse
RST_V_BP, 33, reset v back porch
RST_H_POL, 0, reset hsync polarity (1 = active high)
RST_V_POL, 0, reset vsync polarity

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
enable  in  1  1 = run, 0 = idle
cfg_h_act, cfg_h_fp, cfg_h_sp, cfg_h_bp  in  CNT_W each  horizontal geometry
cfg_v_act, cfg_v_fp, cfg_v_sp, cfg_v_bp  in  CNT_W each  vertical geometry
cfg_h_pol, cfg_v_pol  in  1 each  sync polarities
cfg_load  in  1  one-cycle pulse; capture cfg_* into the pending set
cfg_pending  out  1  pending set not yet applied
hsync, vsync  out  1  sync outputs, polarity per active set
de  out  1  active-video enable
pixel_x, pixel_y  out  CNT_W  coordinates of the current output pixel
line_start  out  1  pulse with h position 0 of every line
frame_start  out  1  pulse with h=0, v=0
hblank, vblank  out  1  h >= h_act; v >= v_act

Behaviour:
- Reset (asynchronous, active-low rst_n; clock clk):
  - Active set = RST_* values; pending empty; h_cnt = v_cnt = 0.
  - hsync = ~RST_H_POL, vsync = ~RST_V_POL; de, line_start, frame_start, cfg_pending = 0.
  - pixel_x = pixel_y = 0; hblank = vblank = 0.
- Active set: on apply, precompute and store h_total-1, h_sync_start, h_sync_end, and the same for v. Sums are done at CNT_W+1 bits.
- Config legality: each field >= 1; totals <= 2^CNT_W. Behaviour outside this range is undefined, and the bench must not drive it.
- Counters:
  - h_cnt wraps at h_total-1. v_cnt increments on h wrap and wraps at v_total-1.
  - frame_end = h wrap AND v wrap.
- Output latency: exactly 1 cycle. All outputs for counter state (h, v) appear registered on the next cycle, mutually aligned.
- hsync asserted for h_act+h_fp <= h < h_act+h_fp+h_sp. Same rule for vsync using v.
- de = (h < h_act) && (v < v_act). pixel_x = h, pixel_y = v, including blanking.
- line_start = (h == 0). frame_start = (h == 0 && v == 0).
- Config handshake:
  - cfg_load with no frame_end that cycle: cfg_* captured into pending; cfg_pending = 1 next cycle.
  - A later cfg_load before apply overwrites pending (last wins).
  - At frame_end with pending valid: pending copied to active; counters go to 0; the next cycle runs the new mode; cfg_pending clears.
  - cfg_load coincident with frame_end: cfg_* go directly to active, bypassing pending. Any older pending is discarded; cfg_pending = 0.
  - Mid-frame, the active set never changes.
- enable = 0:
  - Counters held at 0.
  - Outputs forced to the reset-inactive state using the active polarities: de, strobes and blank flags = 0.
  - Pending set applied immediately. cfg_load while idle writes straight to active.
- enable rising: the first counted cycle is h=0, v=0. frame_start appears 1 cycle later.
- Enable dropped mid-frame: counters go to 0 on the next edge; the frame is abandoned.
- Reset mid-frame: same result as power-on reset.

Decomposition:
- Package vtg_pkg:
  - CNT_W default.
  - Timing-config struct with fields act, fp, sp, bp and pol for each axis.
  - Derived-limits struct with total_m1, sync_start, sync_end.
  - Function computing the limits from a config.
  - VGA 640x480@60 default constants.
- Sub-module vtg_axis, instantiated twice (h and v):
  - Counter, wrap detect, and sync/active/blank decode for one axis.
  - Counts on an advance input (1 for h; h wrap for v).
  - Outputs wrap, cnt, in_active, in_sync.
- Top level owns the shadow/pending logic, enable and output registers.

Test Plan:
- Default 640x480 after reset: line period 800 clk; de high 640 clk per line; hsync low at h = 656..751; vsync low at v = 490..491; frame = 420000 clk; one frame_start per frame.
- Tiny mode (h 4/1/2/1, v 3/1/1/1, pols 1/1) loaded while idle, then enable: line = 8 clk; hsync high at h = 5..6; de pattern 11110000 on v = 0..2; frame = 48 clk. Check the 1-cycle alignment of all outputs against the counters.
- cfg_load of the tiny mode at v = 100 of a default frame: cfg_pending = 1 until frame_end; the remainder of the frame keeps default timing; the first new frame_start is followed by 8-clk lines.
- cfg_load exactly on the frame_end cycle: new mode is active in the following frame; cfg_pending never goes to 1.
- Two cfg_load pulses in one frame (modes A then B): only B is applied at the boundary.
- enable dropped at h = 300, v = 50, then restored after 10 clk: outputs inactive while idle; restart at 0,0; frame_start 1 cycle after resume. Repeat with rst_n pulsed mid-frame: outputs return to reset values immediately (asynchronously).
